// File: rtl/baud_tick_gen_pkg.sv
// Shared constants and types for the UART baud-rate generator.
// Reset divisor is fixed point: 5208 / 16 = 325.5 clk per oversample tick.
package baud_tick_gen_pkg;

   localparam int BTG_DEFAULT_DIV = 5208;
   localparam int BTG_MIN_DIV     = 2;
   localparam int BTG_OVERSAMPLE  = 16;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } btg_state_t;

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: adds the divisor fraction once per
// oversample period; the carry stretches the following period by one clk.
module baud_frac_acc #(
   parameter  int FRAC_W = 4,
   localparam int FW     = (FRAC_W > 0) ? FRAC_W : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_clr,
   input  logic          i_add,
   input  logic [FW-1:0] i_frac,
   output logic          o_extra
);

   generate
      if (FRAC_W > 0) begin : g_acc
         logic [FW-1:0] r_acc;
         logic          r_extra;
         logic [FW:0]   w_sum;

         assign w_sum = {1'b0, r_acc} + {1'b0, i_frac};

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_acc   <= '0;
               r_extra <= 1'b0;
            end else if (i_clr) begin
               r_acc   <= '0;
               r_extra <= 1'b0;
            end else if (i_add) begin
               r_acc   <= w_sum[FW-1:0];
               r_extra <= w_sum[FW];
            end
         end

         assign o_extra = r_extra;
      end else begin : g_none
         logic w_unused;
         assign w_unused = &{1'b0, clk, reset, i_clr, i_add, i_frac};
         assign o_extra  = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable baud-rate generator: oversample, mid-bit and baud enable
// ticks from a fixed-point divisor with glitch-free reload and resync.
module baud_tick_gen
   import baud_tick_gen_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int FRAC_W      = 4,
   parameter int OVERSAMPLE  = BTG_OVERSAMPLE,
   parameter int DEFAULT_DIV = BTG_DEFAULT_DIV
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [DIV_W+FRAC_W-1:0] div_value,
   input  logic                    div_load,
   input  logic                    resync,
   output logic                    os_tick,
   output logic                    mid_tick,
   output logic                    baud_tick,
   output logic                    clk_uart,
   output logic                    cfg_err
);

   localparam int W   = DIV_W + FRAC_W;
   localparam int FW  = (FRAC_W > 0) ? FRAC_W : 1;
   localparam int OSW = $clog2(OVERSAMPLE);
   localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);
   localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);

   btg_state_t       r_state;
   logic [W-1:0]     r_shadow;
   logic [W-1:0]     r_active;
   logic             r_pend;
   logic             r_cfg_err;
   logic [DIV_W:0]   r_cnt;
   logic [OSW-1:0]   r_os_cnt;
   logic             r_os;
   logic             r_mid;
   logic             r_baud;
   logic             r_clk_uart;

   logic [DIV_W-1:0] w_ld_int;
   logic             w_ld_bad;
   logic [W-1:0]     w_ld_val;
   logic [W-1:0]     w_src;
   logic [DIV_W-1:0] w_n;
   logic [FW-1:0]    w_frac;
   logic             w_extra;
   logic [DIV_W:0]   w_last;
   logic             w_hit;
   logic             w_baud_hit;
   logic             w_idle;
   logic             w_apply;

   assign w_ld_int = div_value[W-1:FRAC_W];
   assign w_ld_bad = w_ld_int < DIV_W'(BTG_MIN_DIV);

   always_comb begin
      w_ld_val = div_value;
      if (w_ld_bad)
         w_ld_val[W-1:FRAC_W] = DIV_W'(BTG_MIN_DIV);
   end

   assign w_n    = r_active[W-1:FRAC_W];
   assign w_frac = (FRAC_W > 0) ? r_active[FW-1:0] : '0;

   // Terminal count is N-1, or N when the accumulator carried.
   assign w_last = {1'b0, w_n} - (DIV_W+1)'(1)
                 + {{DIV_W{1'b0}}, w_extra};

   assign w_hit      = enable && !resync && (r_cnt == w_last);
   assign w_baud_hit = w_hit && (r_os_cnt == OS_LAST);
   assign w_idle     = !enable || (r_state == ST_IDLE);

   // A load coinciding with an update point takes effect right away.
   assign w_src   = div_load ? w_ld_val : r_shadow;
   assign w_apply = (div_load || r_pend)
                 && (w_idle || resync || w_baud_hit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow  <= W'(DEFAULT_DIV);
         r_active  <= W'(DEFAULT_DIV);
         r_pend    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         if (div_load) begin
            r_shadow  <= w_ld_val;
            r_cfg_err <= w_ld_bad;
         end
         if (w_apply) begin
            r_active <= w_src;
            r_pend   <= 1'b0;
         end else if (div_load) begin
            r_pend <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_os_cnt   <= '0;
         r_os       <= 1'b0;
         r_mid      <= 1'b0;
         r_baud     <= 1'b0;
         r_clk_uart <= 1'b0;
      end else begin
         r_state <= enable ? ST_RUN : ST_IDLE;
         r_os    <= 1'b0;
         r_mid   <= 1'b0;
         r_baud  <= 1'b0;
         if (!enable || resync) begin
            r_cnt      <= '0;
            r_os_cnt   <= '0;
            r_clk_uart <= 1'b0;
         end else if (w_hit) begin
            r_cnt    <= '0;
            r_os     <= 1'b1;
            r_os_cnt <= (r_os_cnt == OS_LAST) ? '0
                      : r_os_cnt + OSW'(1);
            if (r_os_cnt == OS_MID) begin
               r_mid      <= 1'b1;
               r_clk_uart <= 1'b1;
            end
            if (r_os_cnt == OS_LAST) begin
               r_baud     <= 1'b1;
               r_clk_uart <= 1'b0;
            end
         end else begin
            r_cnt <= r_cnt + (DIV_W+1)'(1);
         end
      end
   end

   baud_frac_acc #(
      .FRAC_W (FRAC_W)
   ) u_frac (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (!enable || resync),
      .i_add   (w_hit),
      .i_frac  (w_frac),
      .o_extra (w_extra)
   );

   assign os_tick   = r_os;
   assign mid_tick  = r_mid;
   assign baud_tick = r_baud;
   assign clk_uart  = r_clk_uart;
   assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: divisor table plus reload, resync, reset and
// enable-drop sequences, with expected tick events held in a queue.
module tb_baud_tick_gen;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        enable    = 1'b0;
   logic        div_load  = 1'b0;
   logic        resync    = 1'b0;
   logic [19:0] div_value = '0;
   logic        os_tick;
   logic        mid_tick;
   logic        baud_tick;
   logic        clk_uart;
   logic        cfg_err;

   int cyc   = 0;
   int t0    = 0;
   int total = 0;
   int bad   = 0;

   typedef struct {
      int   t;
      logic os;
      logic mid;
      logic baud;
      logic cu;
   } ev_t;

   typedef struct {
      logic [19:0] div;
      int          n;
      int          f;
      logic        err;
      int          k;
   } vec_t;

   ev_t  q[$];
   vec_t tbl[8];

   baud_tick_gen dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .div_value (div_value),
      .div_load  (div_load),
      .resync    (resync),
      .os_tick   (os_tick),
      .mid_tick  (mid_tick),
      .baud_tick (baud_tick),
      .clk_uart  (clk_uart),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s t=%0d act=%0h exp=%0h", nm, cyc - t0, act, exp);
      end
   endtask

   // Tick events pack as (time << 4) | {os, mid, baud, clk_uart}.
   task automatic mon();
      ev_t e;
      int  act;
      int  exp;
      if (os_tick || mid_tick || baud_tick) begin
         if (q.size() == 0) begin
            chk("unexpected_tick", int'({os_tick, mid_tick, baud_tick}), 0);
         end else begin
            e   = q.pop_front();
            act = ((cyc - t0) << 4)
                | int'({os_tick, mid_tick, baud_tick, clk_uart});
            exp = (e.t << 4) | int'({e.os, e.mid, e.baud, e.cu});
            chk("tick", act, exp);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      mon();
   endtask

   task automatic run_until(input int t);
      while (cyc - t0 < t) step();
   endtask

   // Expected os ticks k0..k1 of a run starting at base; period j of the
   // run is n plus the carry of the (j-1)th fraction add.
   task automatic push_seq(input int n, input int f, input int k0,
                           input int k1, input int base, output int tl);
      ev_t e;
      int  t;
      int  j;
      t = base;
      for (int k = k0; k <= k1; k++) begin
         j = k - k0 + 1;
         t += n;
         if (j >= 2) t += (f * (j - 1)) / 16 - (f * (j - 2)) / 16;
         e.t    = t;
         e.os   = 1'b1;
         e.mid  = (k % 16 == 8);
         e.baud = (k % 16 == 0);
         e.cu   = (k % 16 >= 8);
         q.push_back(e);
      end
      tl = t;
   endtask

   task automatic load_idle(input logic [19:0] d);
      enable = 1'b0;
      step();
      step();
      div_value = d;
      div_load  = 1'b1;
      step();
      div_load  = 1'b0;
      step();
   endtask

   task automatic start();
      enable = 1'b1;
      t0     = cyc;
   endtask

   task automatic finish_run(input int tl);
      run_until(tl);
      enable = 1'b0;
      step();
      chk("drain", q.size(), 0);
   endtask

   initial begin
      int tl;

      tbl[0] = '{20'h00040, 4, 0,  1'b0, 32};
      tbl[1] = '{20'h00048, 4, 8,  1'b0, 32};
      tbl[2] = '{20'h00024, 2, 4,  1'b0, 32};
      tbl[3] = '{20'h00010, 2, 0,  1'b1, 32};
      tbl[4] = '{20'h00030, 3, 0,  1'b0, 32};
      tbl[5] = '{20'h00018, 2, 8,  1'b1, 32};
      tbl[6] = '{20'h00000, 2, 0,  1'b1, 16};
      tbl[7] = '{20'h0002F, 2, 15, 1'b0, 32};

      repeat (3) @(negedge clk);
      chk("reset_out", int'({os_tick, mid_tick, baud_tick, clk_uart, cfg_err}), 0);
      reset = 1'b0;
      step();

      foreach (tbl[i]) begin
         load_idle(tbl[i].div);
         chk("cfg_err", int'(cfg_err), int'(tbl[i].err));
         start();
         push_seq(tbl[i].n, tbl[i].f, 1, tbl[i].k, 0, tl);
         finish_run(tl);
      end

      // Reload while running waits for the baud boundary.
      load_idle(20'h00040);
      start();
      push_seq(4, 0, 1, 16, 0, tl);
      run_until(21);
      div_value = 20'h00080;
      div_load  = 1'b1;
      step();
      div_load  = 1'b0;
      push_seq(8, 0, 17, 32, 64, tl);
      finish_run(tl);

      // Resync 10 clk after baud, then resync colliding with a tick
      // together with a load.
      load_idle(20'h00040);
      start();
      push_seq(4, 0, 1, 18, 0, tl);
      run_until(74);
      resync = 1'b1;
      step();
      resync = 1'b0;
      chk("resync_quiet", int'({os_tick, mid_tick, baud_tick}), 0);
      push_seq(4, 0, 1, 2, 75, tl);
      run_until(86);
      resync    = 1'b1;
      div_value = 20'h00050;
      div_load  = 1'b1;
      step();
      resync    = 1'b0;
      div_load  = 1'b0;
      chk("resync_hit_quiet", int'({os_tick, mid_tick, baud_tick}), 0);
      push_seq(5, 0, 1, 16, 87, tl);
      finish_run(tl);

      // Pending load is applied at resync.
      load_idle(20'h00040);
      start();
      push_seq(4, 0, 1, 4, 0, tl);
      run_until(13);
      div_value = 20'h00060;
      div_load  = 1'b1;
      step();
      div_load  = 1'b0;
      run_until(19);
      resync = 1'b1;
      step();
      resync = 1'b0;
      push_seq(6, 0, 1, 16, 20, tl);
      finish_run(tl);

      // Asynchronous reset mid-period, then default divisor runs.
      load_idle(20'h00040);
      start();
      push_seq(4, 0, 1, 10, 0, tl);
      run_until(42);
      chk("pre_reset_clk_uart", int'(clk_uart), 1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset", int'({os_tick, mid_tick, baud_tick, clk_uart, cfg_err}), 0);
      chk("pre_reset_drain", q.size(), 0);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      t0    = cyc;
      push_seq(325, 8, 1, 1, 0, tl);
      finish_run(tl);

      // Drop enable where a tick would fire; restart from zero.
      load_idle(20'h00040);
      start();
      push_seq(4, 0, 1, 10, 0, tl);
      run_until(43);
      enable = 1'b0;
      step();
      chk("idle_quiet", int'({os_tick, mid_tick, baud_tick, clk_uart}), 0);
      chk("idle_drain", q.size(), 0);
      step();
      start();
      push_seq(4, 0, 1, 16, 0, tl);
      finish_run(tl);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
